// File: rtl/vga_arb_pkg.sv
// Shared constants for the VGA pixel arbiter: default pixel field widths and arbitration modes.
// Also provides the grant index width helper used by the interface and the top.
package vga_arb_pkg;
   localparam int DEF_COORD_W  = 15;
   localparam int DEF_COLOUR_W = 9;
   localparam int MODE_FIXED   = 0;
   localparam int MODE_RR      = 1;

   function automatic int grant_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/vga_pixel_arbiter_if.sv
// Channel-side write requests and VGA-side pixel outputs of the pixel arbiter.
// master drives requests and observes outputs; slave is the arbiter itself.
interface vga_pixel_arbiter_if
   import vga_arb_pkg::*;
#(
   parameter int NUM_CH   = 2,
   parameter int COORD_W  = DEF_COORD_W,
   parameter int COLOUR_W = DEF_COLOUR_W
) ();
   localparam int GW = grant_w(NUM_CH);

   logic                         enable;
   logic [NUM_CH-1:0]            ch_valid;
   logic [NUM_CH-1:0]            ch_ready;
   logic [NUM_CH*COORD_W-1:0]    ch_coord;
   logic [NUM_CH*COLOUR_W-1:0]   ch_colour;
   logic [NUM_CH-1:0]            ch_flush;
   logic [NUM_CH-1:0]            ch_empty;
   logic [COORD_W-1:0]           coordinates;
   logic [COLOUR_W-1:0]          colour;
   logic                         VGA_write_enable;
   logic [GW-1:0]                grant_ch;

   modport master (
      output enable, ch_valid, ch_coord, ch_colour, ch_flush,
      input  ch_ready, ch_empty, coordinates, colour, VGA_write_enable, grant_ch
   );

   modport slave (
      input  enable, ch_valid, ch_coord, ch_colour, ch_flush,
      output ch_ready, ch_empty, coordinates, colour, VGA_write_enable, grant_ch
   );
endinterface

// File: rtl/vga_pixel_arbiter_fifo.sv
// Per-channel pixel FIFO with synchronous flush; head entry is visible combinationally on dout.
// Push refused when full (even if popped that cycle); flush overrides push and pop.
module pixel_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 24
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic [W-1:0] mem [DEPTH];
   logic         do_push;
   logic         do_pop;

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign dout    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end
endmodule

// File: rtl/vga_pixel_arbiter.sv
// Arbitrates NUM_CH pixel-writer FIFOs onto one VGA write port, one pixel per cycle (fixed priority or round-robin).
// A popped pixel reaches the registered outputs one cycle after its pop edge; enable=0 stalls pops but not pushes.
module vga_pixel_arbiter
   import vga_arb_pkg::*;
#(
   parameter int NUM_CH   = 2,
   parameter int DEPTH    = 4,
   parameter int COORD_W  = DEF_COORD_W,
   parameter int COLOUR_W = DEF_COLOUR_W,
   parameter int MODE     = MODE_FIXED
) (
   input  logic                clk,
   input  logic                resetn,
   vga_pixel_arbiter_if.slave  bus
);
   localparam int W  = COORD_W + COLOUR_W;
   localparam int GW = grant_w(NUM_CH);

   logic [NUM_CH-1:0] full;
   logic [NUM_CH-1:0] empty;
   logic [NUM_CH-1:0] eligible;
   logic [NUM_CH-1:0] pop;
   logic [W-1:0]      fifo_dout [NUM_CH];

   logic              found;
   logic [GW-1:0]     sel;
   logic [W-1:0]      sel_dat;

   logic              p_vld;
   logic [W-1:0]      p_dat;
   logic [GW-1:0]     p_gnt;
   logic [GW-1:0]     last_grant;

   logic              out_we;
   logic [COORD_W-1:0]  out_coord;
   logic [COLOUR_W-1:0] out_colour;
   logic [GW-1:0]     out_grant;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo
      pixel_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
         .clk    (clk),
         .resetn (resetn),
         .push   (bus.ch_valid[g]),
         .pop    (pop[g]),
         .flush  (bus.ch_flush[g]),
         .din    ({bus.ch_coord[g*COORD_W +: COORD_W], bus.ch_colour[g*COLOUR_W +: COLOUR_W]}),
         .dout   (fifo_dout[g]),
         .full   (full[g]),
         .empty  (empty[g])
      );
   end

   assign bus.ch_ready = ~full;
   assign bus.ch_empty = empty;
   assign eligible     = bus.enable ? (~empty & ~bus.ch_flush) : '0;

   // Round-robin: first look above last_grant, then wrap to the low indices.
   always_comb begin
      found   = 1'b0;
      sel     = '0;
      sel_dat = '0;
      pop     = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (!found && eligible[i] && (MODE == MODE_FIXED || i > int'(last_grant))) begin
            found   = 1'b1;
            sel     = GW'(i);
            sel_dat = fifo_dout[i];
            pop[i]  = 1'b1;
         end
      end
      if (MODE == MODE_RR) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (!found && eligible[i]) begin
               found   = 1'b1;
               sel     = GW'(i);
               sel_dat = fifo_dout[i];
               pop[i]  = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         p_vld      <= 1'b0;
         p_dat      <= '0;
         p_gnt      <= '0;
         last_grant <= GW'(NUM_CH - 1);
         out_we     <= 1'b0;
         out_coord  <= '0;
         out_colour <= '0;
         out_grant  <= '0;
      end else begin
         p_vld <= found;
         if (found) begin
            p_dat      <= sel_dat;
            p_gnt      <= sel;
            last_grant <= sel;
         end
         // The issued pixel drains to the outputs regardless of enable.
         out_we <= p_vld;
         if (p_vld) begin
            out_coord  <= p_dat[W-1:COLOUR_W];
            out_colour <= p_dat[COLOUR_W-1:0];
            out_grant  <= p_gnt;
         end else begin
            out_coord  <= '0;
            out_colour <= '0;
         end
      end
   end

   assign bus.VGA_write_enable = out_we;
   assign bus.coordinates      = out_coord;
   assign bus.colour           = out_colour;
   assign bus.grant_ch         = out_grant;
endmodule

// File: tb/tb_vga_pixel_arbiter.sv
// Bench: fixed-priority 2-channel and round-robin 3-channel arbiters against a queue-based reference model.
module tb_vga_pixel_arbiter;
   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   vga_pixel_arbiter_if #(.NUM_CH(2)) ia ();
   vga_pixel_arbiter_if #(.NUM_CH(3)) ib ();

   vga_pixel_arbiter #(.NUM_CH(2), .DEPTH(4), .MODE(0)) dut_a (.clk(clk), .resetn(resetn), .bus(ia));
   vga_pixel_arbiter #(.NUM_CH(3), .DEPTH(4), .MODE(1)) dut_b (.clk(clk), .resetn(resetn), .bus(ib));

   localparam int DEPTH = 4;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   // stimulus per DUT (d=0: A, d=1: B)
   logic       en    [2];
   logic [7:0] vld   [2];
   logic [7:0] flush [2];
   logic [14:0] crd  [2][8];
   logic [8:0]  col  [2][8];

   // reference model
   logic [23:0] mq [16][$];
   int          mlast    [2];
   logic        pend_vld [2];
   logic [23:0] pend_pix [2];
   int          pend_gnt [2];
   logic        exp_we   [2];
   logic [14:0] exp_crd  [2];
   logic [8:0]  exp_col  [2];
   int          exp_gnt  [2];

   int obs_a_gnt[$], obs_a_cyc[$], obs_b_gnt[$];
   logic [14:0] obs_a_crd[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int nch(input int d);
      return (d == 0) ? 2 : 3;
   endfunction

   task automatic idle();
      for (int d = 0; d < 2; d++) begin
         en[d] = 1'b1; vld[d] = '0; flush[d] = '0;
         for (int c = 0; c < 8; c++) begin crd[d][c] = '0; col[d][c] = '0; end
      end
   endtask

   task automatic apply();
      ia.enable = en[0]; ia.ch_valid = vld[0][1:0]; ia.ch_flush = flush[0][1:0];
      for (int c = 0; c < 2; c++) begin
         ia.ch_coord[c*15 +: 15] = crd[0][c];
         ia.ch_colour[c*9 +: 9]  = col[0][c];
      end
      ib.enable = en[1]; ib.ch_valid = vld[1][2:0]; ib.ch_flush = flush[1][2:0];
      for (int c = 0; c < 3; c++) begin
         ib.ch_coord[c*15 +: 15] = crd[1][c];
         ib.ch_colour[c*9 +: 9]  = col[1][c];
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int c = 0; c < 8; c++) mq[d*8+c].delete();
         mlast[d] = nch(d) - 1;
         pend_vld[d] = 1'b0; pend_pix[d] = '0; pend_gnt[d] = 0;
         exp_we[d] = 1'b0; exp_crd[d] = '0; exp_col[d] = '0; exp_gnt[d] = 0;
      end
   endtask

   // One clock edge of the specified behaviour: show the pending pixel, pick a winner, then push/flush.
   task automatic model_edge(input int d);
      int n = nch(d);
      int win = -1;
      int sz[8];
      for (int c = 0; c < n; c++) sz[c] = mq[d*8+c].size();
      exp_we[d] = pend_vld[d];
      if (pend_vld[d]) begin
         exp_crd[d] = pend_pix[d][23:9];
         exp_col[d] = pend_pix[d][8:0];
         exp_gnt[d] = pend_gnt[d];
      end else begin
         exp_crd[d] = '0;
         exp_col[d] = '0;
      end
      if (en[d]) begin
         for (int k = 0; k < n; k++) begin
            int c = (d == 1) ? (mlast[d] + 1 + k) % n : k;
            if (win < 0 && sz[c] > 0 && !flush[d][c]) win = c;
         end
      end
      pend_vld[d] = (win >= 0);
      if (win >= 0) begin
         pend_pix[d] = mq[d*8+win].pop_front();
         pend_gnt[d] = win;
         mlast[d]    = win;
      end
      for (int c = 0; c < n; c++) begin
         if (flush[d][c]) mq[d*8+c].delete();
         else if (vld[d][c] && sz[c] < DEPTH) mq[d*8+c].push_back({crd[d][c], col[d][c]});
      end
   endtask

   task automatic check_dut(input int d);
      string p = (d == 0) ? "a" : "b";
      logic [31:0] we, cr, co, gn, rd, em, erd, eem;
      erd = '0; eem = '0;
      for (int c = 0; c < nch(d); c++) begin
         erd[c] = (mq[d*8+c].size() < DEPTH);
         eem[c] = (mq[d*8+c].size() == 0);
      end
      if (d == 0) begin
         we = 32'(ia.VGA_write_enable); cr = 32'(ia.coordinates); co = 32'(ia.colour);
         gn = 32'(ia.grant_ch); rd = 32'(ia.ch_ready); em = 32'(ia.ch_empty);
      end else begin
         we = 32'(ib.VGA_write_enable); cr = 32'(ib.coordinates); co = 32'(ib.colour);
         gn = 32'(ib.grant_ch); rd = 32'(ib.ch_ready); em = 32'(ib.ch_empty);
      end
      check_eq({p, "_we"}, we, 32'(exp_we[d]));
      check_eq({p, "_coord"}, cr, 32'(exp_crd[d]));
      check_eq({p, "_colour"}, co, 32'(exp_col[d]));
      check_eq({p, "_grant"}, gn, 32'(exp_gnt[d]));
      check_eq({p, "_ready"}, rd, erd);
      check_eq({p, "_empty"}, em, eem);
   endtask

   task automatic step();
      apply();
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      cyc++;
      #1;
      check_dut(0);
      check_dut(1);
      if (ia.VGA_write_enable) begin
         obs_a_gnt.push_back(int'(ia.grant_ch));
         obs_a_crd.push_back(ia.coordinates);
         obs_a_cyc.push_back(cyc);
      end
      if (ib.VGA_write_enable) obs_b_gnt.push_back(int'(ib.grant_ch));
   endtask

   task automatic clear_obs();
      obs_a_gnt.delete(); obs_a_crd.delete(); obs_a_cyc.delete(); obs_b_gnt.delete();
   endtask

   // Reset asserted between edges; outputs must clear without waiting for a clock.
   task automatic mid_reset();
      #2 resetn = 1'b0;
      #1;
      model_reset();
      check_dut(0);
      check_dut(1);
      idle();
      apply();
      @(posedge clk);
      #1 resetn = 1'b1;
   endtask

   initial begin
      resetn = 1'b0;
      idle();
      apply();
      model_reset();
      #1;
      check_dut(0);
      check_dut(1);
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;

      // ch0 and ch1 push 3 pixels together: ch0 drains first, six strobes back-to-back
      clear_obs();
      for (int k = 0; k < 3; k++) begin
         idle(); vld[0] = 8'b11;
         crd[0][0] = 15'h100 + 15'(k); col[0][0] = 9'($urandom);
         crd[0][1] = 15'h200 + 15'(k); col[0][1] = 9'($urandom);
         step();
      end
      idle();
      repeat (6) step();
      check_eq("prio_count", obs_a_gnt.size(), 6);
      for (int k = 0; k < 6 && k < obs_a_gnt.size(); k++) begin
         check_eq("prio_grant", obs_a_gnt[k], (k < 3) ? 0 : 1);
         check_eq("prio_coord", obs_a_crd[k], (k < 3) ? 32'h100 + k : 32'h200 + k - 3);
         check_eq("prio_b2b", obs_a_cyc[k], obs_a_cyc[0] + k);
      end

      // round-robin: 3 channels preloaded with 2 pixels each
      mid_reset();
      clear_obs();
      for (int k = 0; k < 2; k++) begin
         idle(); en[1] = 1'b0; vld[1] = 8'b111;
         for (int c = 0; c < 3; c++) begin crd[1][c] = 15'($urandom); col[1][c] = 9'($urandom); end
         step();
      end
      idle();
      repeat (8) step();
      check_eq("rr_count", obs_b_gnt.size(), 6);
      for (int k = 0; k < 6 && k < obs_b_gnt.size(); k++) check_eq("rr_grant", obs_b_gnt[k], k % 3);

      // enable low, five pushes into a depth-4 FIFO: fifth refused
      clear_obs();
      for (int k = 0; k < 5; k++) begin
         idle(); en[0] = 1'b0; vld[0] = 8'b01;
         crd[0][0] = 15'h300 + 15'(k); col[0][0] = 9'($urandom);
         step();
         if (k >= 3) check_eq("full_ready0", 32'(ia.ch_ready[0]), 0);
      end
      idle();
      repeat (6) step();
      check_eq("full_count", obs_a_crd.size(), 4);
      for (int k = 0; k < 4 && k < obs_a_crd.size(); k++) check_eq("full_order", obs_a_crd[k], 32'h300 + k);

      // flush of ch1 together with a push: all four pixels vanish
      clear_obs();
      for (int k = 0; k < 4; k++) begin
         idle(); en[0] = 1'b0; vld[0] = 8'b10;
         crd[0][1] = 15'h400 + 15'(k); col[0][1] = 9'($urandom);
         if (k == 3) flush[0] = 8'b10;
         step();
      end
      check_eq("flush_empty1", 32'(ia.ch_empty[1]), 1);
      idle();
      repeat (4) step();
      check_eq("flush_none", obs_a_crd.size(), 0);

      // all-ones pixel: strobe after the second edge past the push, then back to zero
      idle(); vld[0] = 8'b01; crd[0][0] = 15'h7FFF; col[0][0] = 9'h1FF;
      step();
      check_eq("lat_we_n", 32'(ia.VGA_write_enable), 0);
      idle();
      step();
      check_eq("lat_we_n1", 32'(ia.VGA_write_enable), 0);
      step();
      check_eq("lat_we_n2", 32'(ia.VGA_write_enable), 1);
      check_eq("lat_coord", 32'(ia.coordinates), 32'h7FFF);
      check_eq("lat_colour", 32'(ia.colour), 32'h1FF);
      step();
      check_eq("lat_idle", {ia.VGA_write_enable, ia.coordinates, ia.colour}, 0);

      // reset with pixels in flight: nothing emitted afterwards
      for (int k = 0; k < 3; k++) begin
         idle(); en[0] = 1'b0; vld[0] = 8'b01;
         crd[0][0] = 15'h500 + 15'(k); col[0][0] = 9'h0AA;
         step();
      end
      idle();
      repeat (2) step();
      check_eq("rst_pre_we", 32'(ia.VGA_write_enable), 1);
      mid_reset();
      clear_obs();
      idle();
      repeat (4) step();
      check_eq("rst_none", obs_a_crd.size(), 0);

      // randomized traffic, enable toggling and occasional flushes
      for (int t = 0; t < 600; t++) begin
         for (int d = 0; d < 2; d++) begin
            en[d] = ($urandom_range(0, 4) != 0);
            vld[d] = '0; flush[d] = '0;
            for (int c = 0; c < nch(d); c++) begin
               vld[d][c]   = ($urandom_range(0, 3) != 0);
               flush[d][c] = ($urandom_range(0, 19) == 0);
               crd[d][c]   = 15'($urandom);
               col[d][c]   = 9'($urandom);
            end
         end
         step();
      end
      idle();
      repeat (12) step();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/vga_pixel_arbiter.md
VGA_PIXEL_ARBITER -- requirements
Module: vga_pixel_arbiter

Interface
REQ-001 Parameter NUM_CH, default 2: number of pixel-writer channels; legal range 2..8.
REQ-002 Parameter DEPTH, default 4: per-channel FIFO entries; power of two, >=2.
REQ-003 Parameter COORD_W, default 15: coordinate width, packed as {y[6:0], x[7:0]} at 160x120.
REQ-004 Parameter COLOUR_W, default 9: colour width, 3 bits per RGB component.
REQ-005 Parameter MODE, default 0: 0 is fixed priority, 1 is round-robin.
REQ-006 Port clk, input, 1: single system clock, rising edge.
REQ-007 Port resetn, input, 1: asynchronous active-low reset.
REQ-008 Port enable, input, 1: when low, no FIFO pops occur; pushes are still accepted.
REQ-009 Port ch_valid, input, NUM_CH: per-channel write request.
REQ-010 Port ch_ready, output, NUM_CH: per-channel "FIFO not full".
REQ-011 Port ch_coord, input, NUM_CH*COORD_W: packed coordinates; channel i occupies bits [i*COORD_W +: COORD_W].
REQ-012 Port ch_colour, input, NUM_CH*COLOUR_W: packed colours, same packing as ch_coord.
REQ-013 Port ch_flush, input, NUM_CH: synchronous per-channel FIFO clear.
REQ-014 Port ch_empty, output, NUM_CH: per-channel FIFO empty flag.
REQ-015 Port coordinates, output, COORD_W: registered VGA coordinate.
REQ-016 Port colour, output, COLOUR_W: registered VGA colour.
REQ-017 Port VGA_write_enable, output, 1: registered VGA write strobe.
REQ-018 Port grant_ch, output, max(1,$clog2(NUM_CH)): index of the channel whose pixel is currently on the outputs.

Function
REQ-019 Push: channel i SHALL accept an entry on a rising edge where ch_valid[i] && ch_ready[i].
REQ-020 ch_ready[i] SHALL equal !full[i], with no same-cycle pass-through: a full FIFO refuses a push even in a cycle where it is popped.
REQ-021 Arbitration: each cycle where enable=1, exactly one non-empty, non-flushing channel SHALL be popped; no pop occurs if no channel is eligible.
REQ-022 MODE=0: the lowest eligible index SHALL win; channel 0 is the tower-drawing channel and takes precedence.
REQ-023 MODE=1: the search SHALL start at last_grant+1 (modulo NUM_CH); last_grant updates only on a pop.
REQ-024 Latency: a popped entry SHALL appear on coordinates/colour/grant_ch with VGA_write_enable=1 exactly one cycle after the pop edge.
REQ-025 Empty-to-output latency: a push into an empty FIFO at edge N SHALL make that channel eligible at edge N+1, with output at N+2.
REQ-026 Idle output: in cycles with no write, VGA_write_enable, coordinates and colour SHALL be 0, and grant_ch SHALL hold its last value.
REQ-027 Throughput: one pixel per cycle sustained; per-channel FIFO order SHALL be preserved.
REQ-028 Flush: ch_flush[i] SHALL empty FIFO i at that edge; it overrides a simultaneous push, and channel i is excluded from that cycle's arbitration.
REQ-029 Pointers SHALL be $clog2(DEPTH)+1 bits, wrapping naturally; full is defined as MSBs differing with the remaining bits equal.
REQ-030 Deasserting enable SHALL NOT corrupt FIFO contents; the output pixel already issued still completes.

Reset
REQ-031 On resetn=0, asynchronously: all FIFOs empty, ch_ready all 1, ch_empty all 1, VGA_write_enable/coordinates/colour 0, grant_ch 0, and last_grant set to NUM_CH-1 so that channel 0 is searched first.
REQ-032 Reset mid-burst SHALL discard all queued pixels; no write strobe is issued in the cycle after release unless a pop occurs.

Structure
REQ-033 Package vga_arb_pkg SHALL hold the COORD_W and COLOUR_W defaults and the constants MODE_FIXED=0 and MODE_RR=1.
REQ-034 Sub-module pixel_fifo (DEPTH, width COORD_W+COLOUR_W, push/pop/flush, full/empty) SHALL be instantiated NUM_CH times via generate.

Verification
REQ-035 MODE=0: ch0 and ch1 each push 3 pixels in the same cycles -> outputs show the 3 ch0 pixels, then the 3 ch1 pixels, back-to-back, VGA_write_enable=1 for 6 consecutive cycles.
REQ-036 MODE=1, NUM_CH=3: all channels preloaded with 2 pixels -> grant_ch sequence 0,1,2,0,1,2.
REQ-037 DEPTH=4, enable=0: push 5 pixels to ch0 -> ch_ready[0]=0 after the 4th push and the 5th is refused; with enable=1, exactly 4 pixels emerge in order.
REQ-038 ch1 holds 3 pixels; assert ch_flush[1] together with ch_valid[1] -> ch_empty[1]=1 next cycle and none of the 4 pixels is ever output.
REQ-039 Push coord 15'h7FFF colour 9'h1FF to ch0 at edge N -> VGA_write_enable=1 with those values after edge N+2, then 0/0/0 on the following cycle.
REQ-040 Assert resetn=0 between clock edges with 2 pixels queued -> outputs are 0 immediately and nothing is emitted after release.
